// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ravenoc_pkg
//  Description : Shared types and constants for the VC input datapath:
//                flit-type encoding (top FLIT_TYPE_W bits of each flit) and
//                the arbitration-mode selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package ravenoc_pkg;

    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum int {
        ARB_FIXED_HI = 0,
        ARB_FIXED_LO = 1,
        ARB_RR       = 2
    } arb_mode_t;

endpackage
`default_nettype wire

// File: rtl/input_datapath_vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vc_fifo
//  Description : Single virtual-channel flit FIFO. Registered memory, no
//                write-to-read bypass. Pointers carry one extra wrap bit.
//  Ports       : clk, arst (async, active-low)
//                wr_valid_i / wr_ready_o / wr_data_i  - write side
//                rd_valid_o / rd_ready_i / rd_data_o  - read side (head)
//                level_o                              - registered occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    // Full when the addresses match but the wrap bits differ.
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr    = wr_valid_i && !w_full;
    assign w_rd    = rd_ready_i && !w_empty;

    assign wr_ready_o = !w_full;
    assign rd_valid_o = !w_empty;
    assign rd_data_o  = r_mem[r_rd_ptr[PTR_W-2:0]];
    assign level_o    = r_level;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[PTR_W-2:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_datapath_vc.sv
`default_nettype none
// ============================================================================
//  Module      : input_datapath_vc
//  Description : Router input datapath. Demuxes input flits into per-VC
//                FIFOs and drains them onto one output link through a
//                packet-aware (wormhole-locked) arbiter.
//  Ports       : clk, arst (async, active-low)
//                fin_*   - input link (valid/ready, vc id, flit)
//                fout_*  - output link (valid/ready, vc id, flit)
//                vc_level_o - per-VC occupancy, vc_err_o - error pulse
//                vc_flit_cnt_o - per-VC output flit counters (optional)
//  Config      : define RAVENOC_VC_FLIT_CNT_EN to add vc_flit_cnt_o
//  Revision    : 1.0 - initial release
// ============================================================================
module input_datapath_vc
    import ravenoc_pkg::*;
#(
    parameter  int N_VC       = 2,
    parameter  int VC_DEPTH   = 4,
    parameter  int FLIT_WIDTH = 34,
    parameter  int ARB_MODE   = 0,
    localparam int VC_W       = $clog2(N_VC > 1 ? N_VC : 2),
    localparam int LVL_W      = $clog2(VC_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fin_valid_i,
    output logic                  fin_ready_o,
    input  logic [VC_W-1:0]       fin_vc_id_i,
    input  logic [FLIT_WIDTH-1:0] fin_fdata_i,
    output logic                  fout_valid_o,
    input  logic                  fout_ready_i,
    output logic [VC_W-1:0]       fout_vc_id_o,
    output logic [FLIT_WIDTH-1:0] fout_fdata_o,
    output logic [N_VC*LVL_W-1:0] vc_level_o,
`ifdef RAVENOC_VC_FLIT_CNT_EN
    output logic [N_VC*16-1:0]    vc_flit_cnt_o,
`endif
    output logic                  vc_err_o
);

    // Per-VC vectors are padded to the full VC id range so any id can index
    // them safely; pad entries look permanently empty.
    localparam int N_PAD = 1 << VC_W;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [VC_W-1:0]       r_lock_vc;
    logic [VC_W-1:0]       r_rr_last;
    logic                  r_hold;
    logic [VC_W-1:0]       r_hold_vc;
    logic                  r_err;

    logic                  w_bad_vc;
    logic [N_PAD-1:0]      w_nonempty;
    logic [N_PAD-1:0]      w_not_full;
    logic [FLIT_WIDTH-1:0] w_head [N_PAD];
    logic                  w_hi_found, w_lo_found, w_rr_found, w_arb_found;
    logic [VC_W-1:0]       w_hi_vc, w_lo_vc, w_rr_vc, w_arb_vc;
    logic [VC_W-1:0]       w_gnt_vc;
    logic                  w_gnt_valid;
    logic                  w_boundary;
    logic                  w_accept;
    flit_type_t            w_gnt_type;
    flit_type_t            w_lock_type;
    logic                  w_err_next;

    // ---------------------------------------------------------------- input
    assign w_bad_vc    = (int'(fin_vc_id_i) >= N_VC);
    assign fin_ready_o = w_bad_vc ? 1'b1 : w_not_full[fin_vc_id_i];

    for (genvar i = 0; i < N_PAD; i++) begin : g_vc
        if (i < N_VC) begin : g_fifo
            logic w_wr_valid;
            logic w_rd_ready;
            assign w_wr_valid = fin_valid_i && !w_bad_vc && (fin_vc_id_i == VC_W'(i));
            assign w_rd_ready = w_accept && (w_gnt_vc == VC_W'(i));
            vc_fifo #(
                .DEPTH (VC_DEPTH),
                .WIDTH (FLIT_WIDTH)
            ) u_fifo (
                .clk        (clk),
                .arst       (arst),
                .wr_valid_i (w_wr_valid),
                .wr_ready_o (w_not_full[i]),
                .wr_data_i  (fin_fdata_i),
                .rd_valid_o (w_nonempty[i]),
                .rd_ready_i (w_rd_ready),
                .rd_data_o  (w_head[i]),
                .level_o    (vc_level_o[i*LVL_W +: LVL_W])
            );
        end else begin : g_pad
            assign w_nonempty[i] = 1'b0;
            assign w_not_full[i] = 1'b0;
            assign w_head[i]     = '0;
        end
    end

    // -------------------------------------------------------------- arbiter
    // Outside a lock every non-empty VC competes: a stray BODY/TAIL at a head
    // must still drain (as a single flit) or it would block its VC forever.
    // Later loop iterations override earlier ones, so each loop is ordered
    // so that its preferred candidate is visited last.
    always_comb begin
        int v_idx;
        w_hi_found = 1'b0; w_hi_vc = '0;
        w_lo_found = 1'b0; w_lo_vc = '0;
        w_rr_found = 1'b0; w_rr_vc = '0;
        v_idx      = 0;
        for (int i = 0; i < N_VC; i++) begin
            if (w_nonempty[i]) begin w_hi_found = 1'b1; w_hi_vc = VC_W'(i); end
        end
        for (int i = N_VC - 1; i >= 0; i--) begin
            if (w_nonempty[i]) begin w_lo_found = 1'b1; w_lo_vc = VC_W'(i); end
        end
        for (int k = N_VC; k >= 1; k--) begin
            v_idx = (int'(r_rr_last) + k) % N_VC;
            if (w_nonempty[v_idx]) begin w_rr_found = 1'b1; w_rr_vc = VC_W'(v_idx); end
        end
        if (ARB_MODE == int'(ARB_RR)) begin
            w_arb_found = w_rr_found; w_arb_vc = w_rr_vc;
        end else if (ARB_MODE == int'(ARB_FIXED_LO)) begin
            w_arb_found = w_lo_found; w_arb_vc = w_lo_vc;
        end else begin
            w_arb_found = w_hi_found; w_arb_vc = w_hi_vc;
        end
    end

    // ---------------------------------------------------------------- grant
    assign w_lock_type = flit_type_t'(w_head[r_lock_vc][FLIT_WIDTH-1 -: FLIT_TYPE_W]);

    always_comb begin
        w_gnt_vc    = '0;
        w_gnt_valid = 1'b0;
        w_boundary  = 1'b0;
        if (r_state == S_LOCKED) begin
            w_gnt_vc = r_lock_vc;
            if (w_nonempty[r_lock_vc]) begin
                // A new packet start inside a locked packet closes the lock
                // first; the flit itself is arbitrated normally from IDLE.
                if (w_lock_type == HEAD || w_lock_type == HEAD_TAIL) begin
                    w_boundary = 1'b1;
                end else begin
                    w_gnt_valid = 1'b1;
                end
            end
        end else if (r_hold) begin
            // An offered but unaccepted flit keeps its grant so fout_* stay
            // stable even if a higher-priority VC fills meanwhile.
            w_gnt_vc    = r_hold_vc;
            w_gnt_valid = 1'b1;
        end else begin
            w_gnt_vc    = w_arb_vc;
            w_gnt_valid = w_arb_found;
        end
    end

    assign w_gnt_type   = flit_type_t'(w_head[w_gnt_vc][FLIT_WIDTH-1 -: FLIT_TYPE_W]);
    assign w_accept     = w_gnt_valid && fout_ready_i;
    assign fout_valid_o = w_gnt_valid;
    assign fout_vc_id_o = w_gnt_valid ? w_gnt_vc : '0;
    assign fout_fdata_o = w_gnt_valid ? w_head[w_gnt_vc] : '0;

    assign w_err_next = (fin_valid_i && w_bad_vc) || w_boundary ||
                        (w_accept && (r_state == S_IDLE) &&
                         (w_gnt_type == BODY || w_gnt_type == TAIL));
    assign vc_err_o   = r_err;

    // ------------------------------------------------------------- lock FSM
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state   <= S_IDLE;
            r_lock_vc <= '0;
            r_rr_last <= VC_W'(N_VC - 1);
            r_hold    <= 1'b0;
            r_hold_vc <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hold <= 1'b0;
                        if (w_gnt_type == HEAD) begin
                            r_state   <= S_LOCKED;
                            r_lock_vc <= w_gnt_vc;
                        end
                        if (w_gnt_type == HEAD || w_gnt_type == HEAD_TAIL) begin
                            r_rr_last <= w_gnt_vc;
                        end
                    end else if (w_gnt_valid) begin
                        r_hold    <= 1'b1;
                        r_hold_vc <= w_gnt_vc;
                    end
                end
                default: begin
                    if (w_boundary || (w_accept && w_gnt_type == TAIL)) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef RAVENOC_VC_FLIT_CNT_EN
    // ------------------------------------------------------ flit counters
    for (genvar i = 0; i < N_VC; i++) begin : g_cnt
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge arst) begin
            if (!arst) begin
                r_cnt <= '0;
            end else if (w_accept && (w_gnt_vc == VC_W'(i)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign vc_flit_cnt_o[i*16 +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
